// File: rtl/calc_pkg.sv
// calc_pkg: opcodes and FSM state encodings for the calculator core.
// Shared with the toplevel button decoder so both sides agree on op codes.
package calc_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_MUL = 2'd2,
      OP_DIV = 2'd3
   } op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/calc_if.sv
// calc_if: request/result bundle between the calculator toplevel and calc_core.
//   master : drives start/op/signed_mode/in1/in2, observes the result side
//   slave  : calc_core; returns busy/done/result/rem/neg/err
interface calc_if #(
   parameter int WIDTH = 8
);
   import calc_pkg::*;

   logic               start;
   op_e                op;
   logic               signed_mode;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] result;
   logic [WIDTH-1:0]   rem;
   logic               neg;
   logic               err;

   modport master (
      output start, op, signed_mode, in1, in2,
      input  busy, done, result, rem, neg, err
   );

   modport slave (
      input  start, op, signed_mode, in1, in2,
      output busy, done, result, rem, neg, err
   );
endinterface

// File: rtl/calc_seq_unit.sv
// calc_seq_unit: one-bit-per-clock engine shared by multiply and divide.
//   clk, rst  : clock, async active-low reset
//   load_i    : load operands and restart the bit counter
//   is_div_i  : 1 = restoring divide, 0 = shift-add multiply (captured with load_i)
//   opnd_i    : value placed in the low half of the shift register
//               (multiplier for mul, dividend for div)
//   m_i       : value held for the adder (multiplicand for mul, divisor for div)
//   fin_o     : WIDTH steps done since the last load; outputs are final
//   prod_o    : 2*WIDTH product
//   quo_o     : quotient, rem_o : remainder
module calc_seq_unit #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               is_div_i,
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic [WIDTH-1:0]   m_i,
   output logic               fin_o,
   output logic [2*WIDTH-1:0] prod_o,
   output logic [WIDTH-1:0]   quo_o,
   output logic [WIDTH-1:0]   rem_o
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0]   m_q;
   logic               div_q;
   logic [CW-1:0]      cnt_q;

   logic [WIDTH:0]     r;
   logic [WIDTH:0]     a_op;
   logic [WIDTH-1:0]   b_op;
   logic [WIDTH+1:0]   sum;
   logic               qbit;

   // Single adder/subtractor. Mul: high half + (lsb ? multiplicand : 0), then
   // shift right. Div: left-shifted partial remainder minus divisor; a borrow
   // means the trial failed and the old remainder is kept (restoring).
   always_comb begin
      r    = {sh_q[2*WIDTH-1:WIDTH], sh_q[WIDTH-1]};
      a_op = div_q ? r : {1'b0, sh_q[2*WIDTH-1:WIDTH]};
      b_op = (div_q || sh_q[0]) ? m_q : '0;
      sum  = div_q ? ({1'b0, a_op} - {2'b00, b_op})
                   : ({1'b0, a_op} + {2'b00, b_op});
      qbit = ~sum[WIDTH+1];
      if (div_q)
         sh_d = {(qbit ? sum[WIDTH-1:0] : r[WIDTH-1:0]), sh_q[WIDTH-2:0], qbit};
      else
         sh_d = {sum[WIDTH:0], sh_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= CW'(WIDTH);   // parked as finished so it idles after reset
      end else if (load_i) begin
         sh_q  <= {{WIDTH{1'b0}}, opnd_i};
         m_q   <= m_i;
         div_q <= is_div_i;
         cnt_q <= '0;
      end else if (!fin_o) begin
         sh_q  <= sh_d;
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign fin_o  = (cnt_q == CW'(WIDTH));
   assign prod_o = sh_q;
   assign quo_o  = sh_q[WIDTH-1:0];
   assign rem_o  = sh_q[2*WIDTH-1:WIDTH];
endmodule

// File: rtl/calc_core.sv
// calc_core: add/sub/mul/div on two WIDTH-bit operands, unsigned or two's
// complement, result as magnitude + sign for the BCD display path.
//   clk, rst : clock, async active-low reset (aborts any operation, no done)
//   calc     : calc_if slave; start/op/signed_mode/in1/in2 captured on
//              start while idle; busy/done/result/rem/neg/err registered
// add/sub and divide-by-zero finish one clock after capture; mul/div run
// WIDTH clocks in calc_seq_unit and raise busy for that time.
module calc_core
   import calc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic  clk,
   input  logic  rst,
   calc_if.slave calc
);
   localparam int AW = WIDTH + 2;   // exact add/sub range for both modes
   localparam int RW = 2 * WIDTH;

   state_e           state_q;
   op_e              op_q;
   logic             sa_q, sb_q, divz_q;
   logic [WIDTH-1:0] ma_q, mb_q;
   logic             busy_q, done_q, neg_q, err_q;
   logic [RW-1:0]    result_q;
   logic [WIDTH-1:0] rem_q;

   logic             sa_d, sb_d, divz_d, is_div, seq_load, seq_fin, fin;
   logic [WIDTH-1:0] ma_d, mb_d, seq_quo, seq_rem;
   logic [RW-1:0]    seq_prod;
   logic [AW-1:0]    va, vb, as_val, as_mag;
   logic             as_neg;

   // Magnitudes are taken at capture; -(-2^(W-1)) wraps to 2^(W-1), which is
   // the correct unsigned magnitude.
   assign sa_d     = SIGNED_EN && calc.signed_mode && calc.in1[WIDTH-1];
   assign sb_d     = SIGNED_EN && calc.signed_mode && calc.in2[WIDTH-1];
   assign ma_d     = sa_d ? -calc.in1 : calc.in1;
   assign mb_d     = sb_d ? -calc.in2 : calc.in2;
   assign is_div   = (calc.op == OP_DIV);
   assign divz_d   = is_div && (calc.in2 == '0);
   assign seq_load = (state_q == S_IDLE) && calc.start &&
                     ((calc.op == OP_MUL) || (is_div && !divz_d));

   calc_seq_unit #(.WIDTH(WIDTH)) u_seq (
      .clk      (clk),
      .rst      (rst),
      .load_i   (seq_load),
      .is_div_i (is_div),
      .opnd_i   (is_div ? ma_d : mb_d),
      .m_i      (is_div ? mb_d : ma_d),
      .fin_o    (seq_fin),
      .prod_o   (seq_prod),
      .quo_o    (seq_quo),
      .rem_o    (seq_rem)
   );

   always_comb begin
      va     = sa_q ? -{2'b00, ma_q} : {2'b00, ma_q};
      vb     = sb_q ? -{2'b00, mb_q} : {2'b00, mb_q};
      as_val = (op_q == OP_SUB) ? (va - vb) : (va + vb);
      as_neg = as_val[AW-1];
      as_mag = as_neg ? -as_val : as_val;
   end

   assign fin = (op_q == OP_ADD) || (op_q == OP_SUB) || divz_q || seq_fin;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         divz_q   <= 1'b0;
         ma_q     <= '0;
         mb_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         neg_q    <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         rem_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (calc.start) begin
                  op_q    <= calc.op;
                  sa_q    <= sa_d;
                  sb_q    <= sb_d;
                  ma_q    <= ma_d;
                  mb_q    <= mb_d;
                  divz_q  <= divz_d;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               if (fin) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= divz_q;
                  if (divz_q) begin
                     result_q <= '1;
                     rem_q    <= '0;
                     neg_q    <= 1'b0;
                  end else if (op_q == OP_MUL) begin
                     result_q <= seq_prod;
                     rem_q    <= '0;
                     neg_q    <= (sa_q ^ sb_q) && (seq_prod != '0);
                  end else if (op_q == OP_DIV) begin
                     result_q <= RW'(seq_quo);
                     rem_q    <= seq_rem;
                     neg_q    <= (sa_q ^ sb_q) && (seq_quo != '0);
                  end else begin
                     result_q <= RW'(as_mag);
                     rem_q    <= '0;
                     neg_q    <= as_neg;
                  end
               end else begin
                  busy_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign calc.busy   = busy_q;
   assign calc.done   = done_q;
   assign calc.result = result_q;
   assign calc.rem    = rem_q;
   assign calc.neg    = neg_q;
   assign calc.err    = err_q;
endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: directed checks of calc_core, a WIDTH=4 unsigned instance and a
// WIDTH=8 signed instance sharing clock and reset.
module tb_calc_core;
   import calc_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   calc_if #(.WIDTH(4)) if4 ();
   calc_if #(.WIDTH(8)) if8 ();

   calc_core #(.WIDTH(4), .SIGNED_EN(1'b0)) u4 (
      .clk  (clk),
      .rst  (rst),
      .calc (if4.slave)
   );

   calc_core #(.WIDTH(8), .SIGNED_EN(1'b1)) u8 (
      .clk  (clk),
      .rst  (rst),
      .calc (if8.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a request so it is captured at the next rising edge; returns 1 ns
   // after that edge with start released.
   task automatic go4(input op_e op, input logic [3:0] a, input logic [3:0] b);
      @(negedge clk);
      if4.op = op; if4.in1 = a; if4.in2 = b; if4.signed_mode = 1'b0; if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
   endtask

   task automatic go8(input op_e op, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      if8.op = op; if8.in1 = a; if8.in2 = b; if8.signed_mode = 1'b1; if8.start = 1'b1;
      @(posedge clk); #1;
      if8.start = 1'b0;
   endtask

   task automatic wait_done4(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!if4.done && lat < 30);
   endtask

   task automatic wait_done8(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!if8.done && lat < 30);
   endtask

   task automatic test_reset();
      total++;
      if ({if4.busy, if4.done, if4.neg, if4.err, if4.result, if4.rem} !== 16'h0) begin
         bad++; $display("FAIL reset_w4 got=%h exp=0", {if4.busy, if4.done, if4.neg, if4.err, if4.result, if4.rem});
      end
      total++;
      if ({if8.busy, if8.done, if8.neg, if8.err, if8.result, if8.rem} !== 28'h0) begin
         bad++; $display("FAIL reset_w8 got=%h exp=0", {if8.busy, if8.done, if8.neg, if8.err, if8.result, if8.rem});
      end
   endtask

   task automatic test_add();
      go4(OP_ADD, 4'd9, 4'd7);
      total++;
      if ({if4.busy, if4.done} !== 2'b00) begin
         bad++; $display("FAIL add_early busy,done got=%b exp=00", {if4.busy, if4.done});
      end
      @(posedge clk); #1;
      total++;
      if ({if4.busy, if4.done, if4.neg, if4.err} !== 4'b0100) begin
         bad++; $display("FAIL add_flags got=%b exp=0100", {if4.busy, if4.done, if4.neg, if4.err});
      end
      total++;
      if (if4.result !== 8'd16 || if4.rem !== 4'd0) begin
         bad++; $display("FAIL add_value result=%0d rem=%0d exp 16/0", if4.result, if4.rem);
      end
      @(posedge clk); #1;
      total++;
      if (if4.done !== 1'b0 || if4.result !== 8'd16) begin
         bad++; $display("FAIL add_hold done=%b result=%0d exp 0/16", if4.done, if4.result);
      end
   endtask

   task automatic test_sub();
      go4(OP_SUB, 4'd3, 4'd5);
      @(posedge clk); #1;
      total++;
      if ({if4.done, if4.neg, if4.result} !== {1'b1, 1'b1, 8'd2}) begin
         bad++; $display("FAIL sub_3_5 done=%b neg=%b result=%0d exp 1/1/2", if4.done, if4.neg, if4.result);
      end
      go4(OP_SUB, 4'd5, 4'd5);
      @(posedge clk); #1;
      total++;
      if ({if4.done, if4.neg, if4.result} !== {1'b1, 1'b0, 8'd0}) begin
         bad++; $display("FAIL sub_5_5 done=%b neg=%b result=%0d exp 1/0/0", if4.done, if4.neg, if4.result);
      end
   endtask

   task automatic test_mul();
      logic [1:0] exp_bd;
      go4(OP_MUL, 4'd15, 4'd15);
      total++;
      if (if4.busy !== 1'b0) begin
         bad++; $display("FAIL mul_busy_c0 got=%b exp=0", if4.busy);
      end
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         exp_bd = (i < 5) ? 2'b10 : 2'b01;
         total++;
         if ({if4.busy, if4.done} !== exp_bd) begin
            bad++; $display("FAIL mul_cycle%0d busy,done got=%b exp=%b", i, {if4.busy, if4.done}, exp_bd);
         end
      end
      total++;
      if ({if4.result, if4.rem, if4.neg, if4.err} !== {8'd225, 4'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL mul_15x15 result=%0d rem=%0d neg=%b err=%b exp 225/0/0/0", if4.result, if4.rem, if4.neg, if4.err);
      end
   endtask

   task automatic test_div();
      int lat;
      go4(OP_DIV, 4'd13, 4'd4);
      wait_done4(lat);
      total++;
      if (lat != 5) begin
         bad++; $display("FAIL div_latency got=%0d exp=5", lat);
      end
      total++;
      if ({if4.result, if4.rem, if4.neg, if4.err} !== {8'd3, 4'd1, 1'b0, 1'b0}) begin
         bad++; $display("FAIL div_13_4 result=%0d rem=%0d neg=%b err=%b exp 3/1/0/0", if4.result, if4.rem, if4.neg, if4.err);
      end
   endtask

   task automatic test_div_zero();
      go4(OP_DIV, 4'd13, 4'd0);
      total++;
      if (if4.busy !== 1'b0) begin
         bad++; $display("FAIL divz_busy got=%b exp=0", if4.busy);
      end
      @(posedge clk); #1;
      total++;
      if ({if4.busy, if4.done, if4.err, if4.neg, if4.result, if4.rem} !== {1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 4'h0}) begin
         bad++; $display("FAIL divz busy=%b done=%b err=%b neg=%b result=%h rem=%h exp 0/1/1/0/ff/0",
                         if4.busy, if4.done, if4.err, if4.neg, if4.result, if4.rem);
      end
   endtask

   task automatic test_signed();
      int lat;
      go8(OP_DIV, 8'h80, 8'hFF);   // -128 / -1
      wait_done8(lat);
      total++;
      if (lat != 9) begin
         bad++; $display("FAIL sdiv_latency got=%0d exp=9", lat);
      end
      total++;
      if ({if8.result, if8.rem, if8.neg, if8.err} !== {16'd128, 8'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL sdiv_m128_m1 result=%0d rem=%0d neg=%b err=%b exp 128/0/0/0", if8.result, if8.rem, if8.neg, if8.err);
      end
      go8(OP_MUL, 8'hF9, 8'd3);    // -7 * 3
      wait_done8(lat);
      total++;
      if ({if8.result, if8.neg, if8.err} !== {16'd21, 1'b1, 1'b0}) begin
         bad++; $display("FAIL smul_m7_3 result=%0d neg=%b err=%b exp 21/1/0", if8.result, if8.neg, if8.err);
      end
      go8(OP_DIV, 8'hF9, 8'd2);    // -7 / 2
      wait_done8(lat);
      total++;
      if ({if8.result, if8.rem, if8.neg} !== {16'd3, 8'd1, 1'b1}) begin
         bad++; $display("FAIL sdiv_m7_2 result=%0d rem=%0d neg=%b exp 3/1/1", if8.result, if8.rem, if8.neg);
      end
      go8(OP_ADD, 8'h9C, 8'h9C);   // -100 + -100
      @(posedge clk); #1;
      total++;
      if ({if8.done, if8.result, if8.neg} !== {1'b1, 16'd200, 1'b1}) begin
         bad++; $display("FAIL sadd_m100_m100 done=%b result=%0d neg=%b exp 1/200/1", if8.done, if8.result, if8.neg);
      end
   endtask

   task automatic test_busy_ignore();
      int lat;
      int extra;
      go4(OP_MUL, 4'd3, 4'd5);
      @(posedge clk); #1;
      if4.op = OP_DIV; if4.in1 = 4'd15; if4.in2 = 4'd1; if4.start = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      if4.start = 1'b0;
      wait_done4(lat);
      total++;
      if (lat != 2) begin
         bad++; $display("FAIL ignore_latency got=%0d exp=2", lat);
      end
      total++;
      if (if4.result !== 8'd15 || if4.rem !== 4'd0) begin
         bad++; $display("FAIL ignore_result result=%0d rem=%0d exp 15/0", if4.result, if4.rem);
      end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (if4.done || if4.busy) extra++;
      end
      total++;
      if (extra != 0) begin
         bad++; $display("FAIL ignore_no_second_op active_cycles=%0d exp=0", extra);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      go4(OP_MUL, 4'd15, 4'd15);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      total++;
      if ({if4.busy, if4.done, if4.neg, if4.err, if4.result, if4.rem} !== 16'h0) begin
         bad++; $display("FAIL rst_mid_outputs got=%h exp=0", {if4.busy, if4.done, if4.neg, if4.err, if4.result, if4.rem});
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (if4.done || if4.busy) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL rst_mid_no_done active_cycles=%0d exp=0", seen);
      end
      go4(OP_MUL, 4'd3, 4'd4);
      wait_done4(lat);
      total++;
      if (lat != 5 || if4.result !== 8'd12) begin
         bad++; $display("FAIL rst_mid_recover lat=%0d result=%0d exp 5/12", lat, if4.result);
      end
   endtask

   task automatic test_back_to_back();
      go4(OP_ADD, 4'd1, 4'd2);
      @(posedge clk); #1;
      total++;
      if (if4.done !== 1'b1 || if4.result !== 8'd3) begin
         bad++; $display("FAIL b2b_first done=%b result=%0d exp 1/3", if4.done, if4.result);
      end
      if4.op = OP_SUB; if4.in1 = 4'd2; if4.in2 = 4'd7; if4.start = 1'b1;
      @(posedge clk); #1;
      if4.start = 1'b0;
      total++;
      if (if4.done !== 1'b0) begin
         bad++; $display("FAIL b2b_gap done=%b exp=0", if4.done);
      end
      @(posedge clk); #1;
      total++;
      if ({if4.done, if4.neg, if4.result} !== {1'b1, 1'b1, 8'd5}) begin
         bad++; $display("FAIL b2b_second done=%b neg=%b result=%0d exp 1/1/5", if4.done, if4.neg, if4.result);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b0;
      if4.start = 1'b0; if4.op = OP_ADD; if4.signed_mode = 1'b0; if4.in1 = '0; if4.in2 = '0;
      if8.start = 1'b0; if8.op = OP_ADD; if8.signed_mode = 1'b0; if8.in1 = '0; if8.in2 = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_div_zero();
      test_signed();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
